// File: rtl/card_pkg.sv
// card_pkg: shared types and default geometry for the card sprite reader.
//   color_t      colour code
//   coord_t      pixel coordinate
//   card_addr_t  card image memory address {row, col}
//   CARD_W/CARD_H card bitmap size in pixels, TRANSPARENT_C see-through code
package card_pkg;

    localparam int unsigned CARD_W_LOG2_C = 4;
    localparam int unsigned CARD_H_LOG2_C = 5;
    localparam int unsigned COORD_W_C     = 8;
    localparam int unsigned COLOR_W_C     = 3;

    localparam int unsigned CARD_W = 1 << CARD_W_LOG2_C;
    localparam int unsigned CARD_H = 1 << CARD_H_LOG2_C;

    typedef logic [COLOR_W_C-1:0]                   color_t;
    typedef logic [COORD_W_C-1:0]                   coord_t;
    typedef logic [CARD_W_LOG2_C+CARD_H_LOG2_C-1:0] card_addr_t;

    localparam color_t TRANSPARENT_C = '0;

endpackage

// File: rtl/card_pos_shadow.sv
// card_pos_shadow: double-buffered card origin.
//   A new origin is captured into a shadow register by the pos_load/pos_ready
//   handshake and moved to the active register only on frame_start, so a frame
//   is never drawn with two different origins.
// Ports:
//   clock, reset_n           clock, synchronous active-low reset
//   frame_start              once-per-frame commit pulse
//   pos_load, pos_x, pos_y   origin load request and value
//   pos_ready                no update pending, a new origin can be accepted
//   act_x, act_y             origin currently used by the pixel pipeline
module card_pos_shadow
    import card_pkg::*;
#(
    parameter int unsigned COORD_W = COORD_W_C
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               frame_start,
    input  logic               pos_load,
    input  logic [COORD_W-1:0] pos_x,
    input  logic [COORD_W-1:0] pos_y,
    output logic               pos_ready,
    output logic [COORD_W-1:0] act_x,
    output logic [COORD_W-1:0] act_y
);

    logic [COORD_W-1:0] shadow_x;
    logic [COORD_W-1:0] shadow_y;
    logic               pending;
    logic               accept;

    assign pos_ready = ~pending;
    assign accept    = pos_load && pos_ready;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            shadow_x <= '0;
            shadow_y <= '0;
            act_x    <= '0;
            act_y    <= '0;
            pending  <= 1'b0;
        end else if (frame_start && accept) begin
            // Load coinciding with the commit goes straight to the active origin.
            shadow_x <= pos_x;
            shadow_y <= pos_y;
            act_x    <= pos_x;
            act_y    <= pos_y;
        end else if (frame_start && pending) begin
            act_x   <= shadow_x;
            act_y   <= shadow_y;
            pending <= 1'b0;
        end else if (accept) begin
            shadow_x <= pos_x;
            shadow_y <= pos_y;
            pending  <= 1'b1;
        end
    end

endmodule

// File: rtl/card_sprite_reader.sv
// card_sprite_reader: composites a card bitmap over a 256x240 VGA pixel stream.
//   Stage 0: hit test against the active origin, issue RE/rAddr (registered).
//   Stage 1: card memory returns dataOut; valid/background travel alongside.
//   Stage 2: transparent-aware mux of card colour over background.
//   Latency 2 cycles, one pixel per clock.
// Ports:
//   clock, reset_n                         clock, synchronous active-low reset
//   frame_start                            commits a pending origin
//   pix_valid, pix_x, pix_y, bg_color      input pixel stream
//   card_en                                card visible
//   pos_x, pos_y, pos_load, pos_ready      origin update handshake
//   RE, rAddr, dataOut                     card memory read port
//   valid_out, color_out, card_hit         composited pixel stream
// Configuration macro: CARD_SCALE2X_EN doubles the card footprint (each bitmap
// pixel covers 2x2 screen pixels).
module card_sprite_reader
    import card_pkg::*;
#(
    parameter int unsigned              CARD_W_LOG2 = CARD_W_LOG2_C,
    parameter int unsigned              CARD_H_LOG2 = CARD_H_LOG2_C,
    parameter int unsigned              COORD_W     = COORD_W_C,
    parameter int unsigned              COLOR_W     = COLOR_W_C,
    parameter logic [COLOR_W-1:0]       TRANSPARENT = '0
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              frame_start,
    input  logic                              pix_valid,
    input  logic [COORD_W-1:0]                pix_x,
    input  logic [COORD_W-1:0]                pix_y,
    input  logic [COLOR_W-1:0]                bg_color,
    input  logic                              card_en,
    input  logic [COORD_W-1:0]                pos_x,
    input  logic [COORD_W-1:0]                pos_y,
    input  logic                              pos_load,
    output logic                              pos_ready,
    output logic                              RE,
    output logic [CARD_W_LOG2+CARD_H_LOG2-1:0] rAddr,
    input  logic [COLOR_W-1:0]                dataOut,
    output logic                              valid_out,
    output logic [COLOR_W-1:0]                color_out,
    output logic                              card_hit
);

`ifdef CARD_SCALE2X_EN
    localparam int unsigned FOOT_W_LOG2 = CARD_W_LOG2 + 1;
    localparam int unsigned FOOT_H_LOG2 = CARD_H_LOG2 + 1;
`else
    localparam int unsigned FOOT_W_LOG2 = CARD_W_LOG2;
    localparam int unsigned FOOT_H_LOG2 = CARD_H_LOG2;
`endif
    localparam logic [COORD_W:0] FOOT_W = (COORD_W+1)'(1 << FOOT_W_LOG2);
    localparam logic [COORD_W:0] FOOT_H = (COORD_W+1)'(1 << FOOT_H_LOG2);

    logic [COORD_W-1:0]     act_x;
    logic [COORD_W-1:0]     act_y;
    logic [COORD_W:0]       dx;
    logic [COORD_W:0]       dy;
    logic                   hit0;
    logic [CARD_W_LOG2-1:0] dx_idx;
    logic [CARD_H_LOG2-1:0] dy_idx;
    logic                   valid1;
    logic [COLOR_W-1:0]     bg1;
    logic                   opaque;

    card_pos_shadow #(
        .COORD_W (COORD_W)
    ) u_pos (
        .clock       (clock),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .pos_load    (pos_load),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .pos_ready   (pos_ready),
        .act_x       (act_x),
        .act_y       (act_y)
    );

    // Offsets carry an extra bit so a pixel left of / above the origin becomes
    // a large unsigned value and fails the range test: no wrap-around.
    always_comb begin
        dx   = {1'b0, pix_x} - {1'b0, act_x};
        dy   = {1'b0, pix_y} - {1'b0, act_y};
        hit0 = pix_valid && card_en && (dx < FOOT_W) && (dy < FOOT_H);
`ifdef CARD_SCALE2X_EN
        dx_idx = dx[CARD_W_LOG2:1];
        dy_idx = dy[CARD_H_LOG2:1];
`else
        dx_idx = dx[CARD_W_LOG2-1:0];
        dy_idx = dy[CARD_H_LOG2-1:0];
`endif
    end

    // Stage 0 -> 1: RE doubles as the stage-1 hit flag.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            RE     <= 1'b0;
            rAddr  <= '0;
            valid1 <= 1'b0;
            bg1    <= '0;
        end else begin
            RE     <= hit0;
            valid1 <= pix_valid;
            bg1    <= bg_color;
            if (hit0) begin
                rAddr <= {dy_idx, dx_idx};
            end
        end
    end

    assign opaque = RE && (dataOut != TRANSPARENT);

    // Stage 1 -> 2: compositing; bubbles carry colour 0.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            valid_out <= 1'b0;
            color_out <= '0;
            card_hit  <= 1'b0;
        end else begin
            valid_out <= valid1;
            card_hit  <= valid1 && opaque;
            if (!valid1) begin
                color_out <= '0;
            end else if (opaque) begin
                color_out <= dataOut;
            end else begin
                color_out <= bg1;
            end
        end
    end

endmodule
